// File: rtl/multi_clk_div.sv
// rtl/multi_clk_div.sv - N-channel programmable clock divider / tick generator (optional CLKDIV_SYNC_EN adds sync_in)
module multi_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 40000
) (
  input  logic              in_clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] out_tick,
  output logic [NUM_CH-1:0] out_sq,
  output logic [NUM_CH-1:0] ch_en
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  eff_div [NUM_CH];
  logic [CNT_W-1:0]  cnt_step [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] wr_sel;
  logic              sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  // Per-channel effective divisor, terminal-count detect and next count value
  always_comb begin
    term   = '0;
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_div[i]  = (div_q[i] < MIN_DIV) ? MIN_DIV : div_q[i];
      // >= keeps the wrap safe even if cnt were ever beyond range
      term[i]     = (cnt_q[i] >= eff_div[i] - ONE);
      cnt_step[i] = term[i] ? '0 : cnt_q[i] + ONE;
      wr_sel[i]   = cfg_we && (cfg_ch == 4'(i));
    end
  end

  // Next-state: config write beats sync, sync beats normal counting
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    sq_d      = sq_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_sel[i]) begin
        div_d[i]     = cfg_div;
        en_d[i]      = cfg_en;
        oneshot_d[i] = cfg_oneshot;
        cnt_d[i]     = '0;
        sq_d[i]      = 1'b0;
      end else if (en_q[i] && sync_hit) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (en_q[i]) begin
        cnt_d[i]  = cnt_step[i];
        tick_d[i] = term[i];
        sq_d[i]   = (cnt_step[i] < (eff_div[i] >> 1));
        if (term[i] && oneshot_q[i]) begin
          en_d[i] = 1'b0;
          sq_d[i] = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous reset to the default divisor, all enabled
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= RST_DIV;
        cnt_q[i] <= '0;
      end
      en_q      <= '1;
      oneshot_q <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign out_tick = tick_q;
  assign out_sq   = sq_q;
  assign ch_en    = en_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// tb/tb_multi_clk_div.sv - randomized self-checking bench for multi_clk_div against an elapsed-edge model
module tb_multi_clk_div;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 32;
  localparam int DEFAULT_DIV = 40000;

  logic              in_clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_en;
  logic              cfg_oneshot;
  logic              sync_drv;
`ifdef CLKDIV_SYNC_EN
  logic              sync_in;
`endif
  logic [NUM_CH-1:0] out_tick;
  logic [NUM_CH-1:0] out_sq;
  logic [NUM_CH-1:0] ch_en;

  multi_clk_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .in_clk     (in_clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .cfg_oneshot(cfg_oneshot),
`ifdef CLKDIV_SYNC_EN
    .sync_in    (sync_in),
`endif
    .out_tick   (out_tick),
    .out_sq     (out_sq),
    .ch_en      (ch_en)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: divisor, mode, and edges elapsed since the channel last restarted
  int m_de   [NUM_CH];
  int m_n    [NUM_CH];
  bit m_en   [NUM_CH];
  bit m_os   [NUM_CH];
  bit m_sq   [NUM_CH];
  bit m_tick [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_de[c] = DEFAULT_DIV; m_n[c] = 0; m_en[c] = 1'b1; m_os[c] = 1'b0;
      m_sq[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      m_tick[c] = 1'b0;
      if (cfg_we && int'(cfg_ch) == c) begin
        m_de[c] = (cfg_div < 2) ? 2 : int'(cfg_div);
        m_en[c] = cfg_en; m_os[c] = cfg_oneshot; m_n[c] = 0; m_sq[c] = 1'b0;
      end else if (m_en[c] && sync_drv) begin
        m_n[c] = 0; m_sq[c] = 1'b0;
      end else if (m_en[c]) begin
        m_n[c]++;
        m_tick[c] = (m_n[c] % m_de[c] == 0);
        m_sq[c]   = (m_n[c] % m_de[c]) < (m_de[c] / 2);
        if (m_tick[c] && m_os[c]) begin
          m_en[c] = 1'b0; m_sq[c] = 1'b0; m_n[c] = 0;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string where);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s tick%0d", where, c), 32'(out_tick[c]), 32'(m_tick[c]));
      check($sformatf("%s sq%0d", where, c), 32'(out_sq[c]), 32'(m_sq[c]));
      check($sformatf("%s en%0d", where, c), 32'(ch_en[c]), 32'(m_en[c]));
    end
  endtask

  task automatic set_sync(input logic v);
    sync_drv = v;
`ifdef CLKDIV_SYNC_EN
    sync_in = v;
`endif
  endtask

  task automatic step();
    @(posedge in_clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic cfg_write(input int ch, input int div, input logic en, input logic os);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_div = CNT_W'(div); cfg_en = en; cfg_oneshot = os;
    step();
    cfg_we = 1'b0;
  endtask

  int ticks;
  int edges;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; cfg_oneshot = 1'b0;
    set_sync(1'b0);
    model_reset();
    #12;
    check_outputs("reset");
    check("reset ch_en", 32'(ch_en), 32'hF);
    rst_n = 1'b1;

    // D=4 continuous: four ticks in sixteen edges
    cfg_write(0, 4, 1'b1, 1'b0);
    ticks = 0;
    for (int k = 1; k < 16; k++) begin step(); ticks += int'(out_tick[0]); end
    step(); ticks += int'(out_tick[0]);
    check("d4 ticks", 32'(ticks), 32'd4);

    // One-shot D=5: a single tick, then the channel disables itself
    cfg_write(1, 5, 1'b1, 1'b1);
    ticks = 0;
    for (int k = 0; k < 55; k++) begin step(); ticks += int'(out_tick[1]); end
    check("oneshot ticks", 32'(ticks), 32'd1);
    check("oneshot en", 32'(ch_en[1]), 32'd0);
    check("oneshot sq", 32'(out_sq[1]), 32'd0);

    // D=0 and D=1 both run as D=2
    cfg_write(2, 0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step();
    cfg_write(2, 1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step();

    // Write on the terminal-count edge suppresses the tick
    cfg_write(3, 7, 1'b1, 1'b0);
    for (int k = 0; k < 8 && (m_n[0] % 4) != 3; k++) step();
    check("ch0 at c=3", 32'(m_n[0] % 4), 32'd3);
    cfg_write(0, 6, 1'b1, 1'b0);
    check("write beats tc", 32'(out_tick[0]), 32'd0);
    edges = 0;
    for (int k = 0; k < 20 && !out_tick[0]; k++) begin step(); edges++; end
    check("tick after rewrite", 32'(edges), 32'd6);

`ifdef CLKDIV_SYNC_EN
    cfg_write(0, 4, 1'b1, 1'b0);
    cfg_write(1, 8, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step();
    set_sync(1'b1); step(); set_sync(1'b0);
    edges = 0;
    for (int k = 0; k < 20 && !out_tick[1]; k++) begin step(); edges++; end
    check("sync ch1 first tick", 32'(edges), 32'd8);
    check("sync ticks coincide", 32'(out_tick[0]), 32'd1);
`endif

    // Randomized writes (some to non-existent channels) and sync pulses
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        cfg_we = 1'b1; cfg_ch = 4'($urandom_range(0, 5)); cfg_div = CNT_W'($urandom_range(0, 12));
        cfg_en = ($urandom_range(0, 7) != 0); cfg_oneshot = ($urandom_range(0, 3) == 0);
      end else begin
        cfg_we = 1'b0;
      end
`ifdef CLKDIV_SYNC_EN
      set_sync($urandom_range(0, 19) == 0);
`endif
      step();
    end
    cfg_we = 1'b0;
    set_sync(1'b0);

    // Asynchronous reset mid-period, then default divisor from release
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async reset");
    check("async reset ch_en", 32'(ch_en), 32'hF);
    step();
    step();
    #1;
    rst_n = 1'b1;
    edges = 0;
    for (int k = 0; k < DEFAULT_DIV + 10 && !out_tick[0]; k++) begin step(); edges++; end
    check("default first tick", 32'(edges), 32'(DEFAULT_DIV));
    for (int k = 0; k < 4; k++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
